// File: rtl/food_gen.sv
// food_gen: apple placement, eat detection, score keeping and apple pixel
// overlay for the snake game. A free-running Galois LFSR proposes candidate
// cells. The first legal candidate becomes the apple. When the snake head
// reaches the apple during play, add_cube is raised for a fixed number of
// cycles and the score is incremented.
module food_gen #(
  parameter int          X_MIN     = 1,
  parameter int          X_MAX     = 38,
  parameter int          Y_MIN     = 1,
  parameter int          Y_MAX     = 28,
  parameter int          ADD_HOLD  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         game_status,
  input  logic [5:0]         head_x,
  input  logic [5:0]         head_y,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  output logic [5:0]         apple_x,
  output logic [5:0]         apple_y,
  output logic               apple_valid,
  output logic               add_cube,
  output logic [SCORE_W-1:0] score,
  output logic               apple_show
);

  // Placement / eat controller states
  localparam logic [1:0] ST_PLACE = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_EAT   = 2'b10;

  // Game status encodings (01 behaves like DIE because only PLAY eats)
  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_PLAY    = 2'b10;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Legal apple window, sized to the cell coordinate width
  localparam logic [5:0] X_LO = 6'(X_MIN);
  localparam logic [5:0] X_HI = 6'(X_MAX);
  localparam logic [5:0] Y_LO = 6'(Y_MIN);
  localparam logic [5:0] Y_HI = 6'(Y_MAX);

  // Hold counter counts down from ADD_HOLD-1 to zero
  localparam int                HOLD_W    = (ADD_HOLD > 1) ? $clog2(ADD_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ADD_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ZERO = SCORE_W'(0);

  // Advance a right-shifting Galois LFSR by one step
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_MASK;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Registered state
  logic [15:0]        lfsr_r;
  logic [1:0]         state_r;
  logic [5:0]         apple_x_r;
  logic [5:0]         apple_y_r;
  logic               apple_valid_r;
  logic               add_cube_r;
  logic [SCORE_W-1:0] score_r;
  logic [HOLD_W-1:0]  hold_r;

  // Next-state values
  logic [1:0]         state_s;
  logic [5:0]         apple_x_s;
  logic [5:0]         apple_y_s;
  logic               apple_valid_s;
  logic               add_cube_s;
  logic [SCORE_W-1:0] score_s;
  logic [HOLD_W-1:0]  hold_s;

  // Decoded conditions
  logic [5:0] cand_x_s;
  logic [5:0] cand_y_s;
  logic       cand_ok_s;
  logic       head_hit_s;
  logic       restart_s;
  logic       play_s;

  // Decode the LFSR candidate and the head/apple relationship
  always_comb begin
    cand_x_s   = lfsr_r[5:0];
    cand_y_s   = lfsr_r[13:8];
    restart_s  = (game_status == GS_RESTART);
    play_s     = (game_status == GS_PLAY);
    head_hit_s = (head_x == apple_x_r) && (head_y == apple_y_r);
    // A candidate is usable if it is inside the interior and not under the head
    cand_ok_s  = (cand_x_s >= X_LO) && (cand_x_s <= X_HI) &&
                 (cand_y_s >= Y_LO) && (cand_y_s <= Y_HI) &&
                 !((cand_x_s == head_x) && (cand_y_s == head_y));
  end

  // Controller next-state logic; RESTART overrides every state
  always_comb begin
    state_s       = state_r;
    apple_x_s     = apple_x_r;
    apple_y_s     = apple_y_r;
    apple_valid_s = apple_valid_r;
    add_cube_s    = add_cube_r;
    score_s       = score_r;
    hold_s        = hold_r;
    if (restart_s) begin
      state_s       = ST_PLACE;
      apple_x_s     = 6'd0;
      apple_y_s     = 6'd0;
      apple_valid_s = 1'b0;
      add_cube_s    = 1'b0;
      score_s       = SCORE_ZERO;
      hold_s        = HOLD_ZERO;
    end else begin
      case (state_r)
        ST_PLACE: begin
          if (cand_ok_s) begin
            apple_x_s     = cand_x_s;
            apple_y_s     = cand_y_s;
            apple_valid_s = 1'b1;
            state_s       = ST_WAIT;
          end else begin
            state_s       = ST_PLACE;
          end
        end
        ST_WAIT: begin
          // Only PLAY eats; DIE (and 01) leave the apple in place
          if (play_s && head_hit_s) begin
            add_cube_s    = 1'b1;
            apple_valid_s = 1'b0;
            hold_s        = HOLD_LOAD;
            state_s       = ST_EAT;
            if (score_r != SCORE_MAX) begin
              score_s = score_r + SCORE_ONE;
            end else begin
              score_s = score_r;
            end
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_EAT: begin
          // add_cube was raised on entry; drop it after ADD_HOLD cycles
          if (hold_r == HOLD_ZERO) begin
            add_cube_s = 1'b0;
            state_s    = ST_PLACE;
          end else begin
            hold_s     = hold_r - HOLD_ONE;
          end
        end
        default: begin
          state_s       = ST_PLACE;
          apple_valid_s = 1'b0;
          add_cube_s    = 1'b0;
          hold_s        = HOLD_ZERO;
        end
      endcase
    end
  end

  // LFSR free-runs in every state; only rst_n reloads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Controller and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_PLACE;
      apple_x_r     <= 6'd0;
      apple_y_r     <= 6'd0;
      apple_valid_r <= 1'b0;
      add_cube_r    <= 1'b0;
      score_r       <= SCORE_ZERO;
      hold_r        <= HOLD_ZERO;
    end else begin
      state_r       <= state_s;
      apple_x_r     <= apple_x_s;
      apple_y_r     <= apple_y_s;
      apple_valid_r <= apple_valid_s;
      add_cube_r    <= add_cube_s;
      score_r       <= score_s;
      hold_r        <= hold_s;
    end
  end

  // Pixel overlay: 16x16 cells, visible area only
  always_comb begin
    apple_show = apple_valid_r &&
                 (pos_x < 10'd640) && (pos_y < 10'd480) &&
                 (pos_x[9:4] == apple_x_r) && (pos_y[9:4] == apple_y_r);
  end

  assign apple_x     = apple_x_r;
  assign apple_y     = apple_y_r;
  assign apple_valid = apple_valid_r;
  assign add_cube    = add_cube_r;
  assign score       = score_r;

endmodule

// File: tb/tb_food_gen.sv
// tb_food_gen: directed self-checking bench for food_gen.
module tb_food_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] game_status;
  logic [5:0] head_x, head_y;
  logic [9:0] pos_x, pos_y;
  logic [5:0] apple_x, apple_y;
  logic       apple_valid, add_cube, apple_show;
  logic [7:0] score;

  int total  = 0;
  int passed = 0;

  logic [15:0] m_lfsr;
  logic [15:0] prev_lfsr;
  logic        was_valid;

  food_gen dut (
    .clk(clk), .rst_n(rst_n), .game_status(game_status),
    .head_x(head_x), .head_y(head_y), .pos_x(pos_x), .pos_y(pos_y),
    .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
    .add_cube(add_cube), .score(score), .apple_show(apple_show)
  );

  always #5 clk = ~clk;

  // Reference LFSR used to predict each placed apple
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock; outputs sampled 1 time unit after the edge
  task automatic tick();
    prev_lfsr = m_lfsr;
    was_valid = apple_valid;
    @(posedge clk);
    #1;
    if (apple_valid && !was_valid) begin
      check("place_x", 32'(apple_x), 32'(prev_lfsr[5:0]));
      check("place_y", 32'(apple_y), 32'(prev_lfsr[13:8]));
    end
  endtask

  task automatic wait_valid(input int lim);
    int n = 0;
    while (!apple_valid && n < lim) begin tick(); n++; end
    check("place_timeout", 32'(apple_valid), 32'd1);
  endtask

  task automatic wait_add_low();
    int n = 0;
    while (add_cube && n < 20) begin tick(); n++; end
    check("add_low_timeout", 32'(add_cube), 32'd0);
  endtask

  // Put the head on the apple, take one edge, confirm the eat
  task automatic eat(input int exp_score);
    head_x = apple_x; head_y = apple_y;
    tick();
    check("eat_add", 32'(add_cube), 32'd1);
    check("eat_valid", 32'(apple_valid), 32'd0);
    check("eat_score", 32'(score), 32'(exp_score));
    head_x = 6'd0; head_y = 6'd0;
  endtask

  initial begin
    int hi;
    int exp_score;
    logic seen;
    rst_n = 1'b0; game_status = 2'b10;
    head_x = 6'd10; head_y = 6'd20; pos_x = 10'd0; pos_y = 10'd0;
    was_valid = 1'b0; prev_lfsr = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(apple_x), 32'd0);
    check("rst_y", 32'(apple_y), 32'd0);
    check("rst_valid", 32'(apple_valid), 32'd0);
    check("rst_add", 32'(add_cube), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_show", 32'(apple_show), 32'd0);

    // First placement from seed ACE1: candidates rejected until (14,28)
    rst_n = 1'b1;
    wait_valid(64);
    check("first_x", 32'(apple_x), 32'd14);
    check("first_y", 32'(apple_y), 32'd28);
    check("x_range", 32'(apple_x >= 6'd1 && apple_x <= 6'd38), 32'd1);
    check("y_range", 32'(apple_y >= 6'd1 && apple_y <= 6'd28), 32'd1);
    check("not_head", 32'(apple_x == 6'd10 && apple_y == 6'd20), 32'd0);
    check("score0", 32'(score), 32'd0);

    // Pixel overlay around cell (14,28): x 224..239, y 448..463
    pos_x = 10'd229; pos_y = 10'd463; #1;
    check("show_in", 32'(apple_show), 32'd1);
    pos_x = 10'd240; #1;
    check("show_right", 32'(apple_show), 32'd0);
    pos_x = 10'd229; pos_y = 10'd464; #1;
    check("show_below", 32'(apple_show), 32'd0);
    pos_x = 10'd224; pos_y = 10'd448; #1;
    check("show_corner", 32'(apple_show), 32'd1);
    pos_x = 10'd229; pos_y = 10'd463;

    // First eat: add_cube high exactly 4 cycles, overlay off while invalid
    eat(1);
    check("show_invalid", 32'(apple_show), 32'd0);
    hi = 1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (add_cube) hi++;
      else break;
    end
    check("add_len", 32'(hi), 32'd4);
    check("gap_valid", 32'(apple_valid), 32'd0);
    wait_valid(200);

    // 256 more eats: score saturates at 255
    exp_score = 1;
    for (int i = 0; i < 256; i++) begin
      exp_score = (exp_score < 255) ? exp_score + 1 : 255;
      eat(exp_score);
      wait_add_low();
      wait_valid(200);
    end
    check("score_sat", 32'(score), 32'd255);

    // RESTART on the second EAT cycle
    eat(255);
    tick();
    check("eat2_add", 32'(add_cube), 32'd1);
    game_status = 2'b00;
    tick();
    check("rs_add", 32'(add_cube), 32'd0);
    check("rs_score", 32'(score), 32'd0);
    check("rs_valid", 32'(apple_valid), 32'd0);
    check("rs_x", 32'(apple_x), 32'd0);
    check("rs_y", 32'(apple_y), 32'd0);
    seen = 1'b0;
    repeat (20) begin tick(); if (apple_valid) seen = 1'b1; end
    check("rs_noplace", 32'(seen), 32'd0);
    game_status = 2'b10;
    wait_valid(200);
    check("rs_score_hold", 32'(score), 32'd0);

    eat(1);
    wait_add_low();
    wait_valid(200);

    // DIE (11 then 01) with head on apple: nothing eaten
    game_status = 2'b11;
    head_x = apple_x; head_y = apple_y;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (n == 50) game_status = 2'b01;
      tick();
      if (add_cube || !apple_valid) seen = 1'b1;
    end
    check("die_noeat", 32'(seen), 32'd0);
    check("die_score", 32'(score), 32'd1);

    // Back to PLAY with head already on apple: eat next edge
    game_status = 2'b10;
    tick();
    check("play_eat", 32'(add_cube), 32'd1);
    check("play_score", 32'(score), 32'd2);
    head_x = 6'd0; head_y = 6'd0;

    // Asynchronous reset mid-EAT clears outputs without a clock edge
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_add", 32'(add_cube), 32'd0);
    check("arst_score", 32'(score), 32'd0);
    check("arst_valid", 32'(apple_valid), 32'd0);
    check("arst_x", 32'(apple_x), 32'd0);
    check("arst_y", 32'(apple_y), 32'd0);
    check("arst_show", 32'(apple_show), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
